// File: rtl/conv_window_gen_3x3.sv
// 3x3 sliding-window generator: raster pixel stream in, one packed 9-pixel window out per position.
// Optional 1-pixel zero border is enabled by defining CONV_PAD_EN.
module conv_window_gen_3x3 #(
    parameter int DATA_W = 16,
    parameter int MAX_W  = 256,
    parameter int CNT_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [CNT_W-1:0]    i_cfg_width,
    input  logic [CNT_W-1:0]    i_cfg_height,
    input  logic [1:0]          i_cfg_stride,
    input  logic [DATA_W-1:0]   i_pix_data,
    input  logic                i_pix_valid,
    output logic                o_pix_ready,
    output logic [9*DATA_W-1:0] o_win_data,
    output logic                o_win_valid,
    input  logic                i_win_ready,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_cfg_err
);

    // Internal grid counters carry one extra bit so a padded height never wraps.
    localparam int GW = CNT_W + 1;
    localparam int AW = $clog2(MAX_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [GW-1:0]       r_row;
    logic [GW-1:0]       r_col;
    logic [GW-1:0]       r_wi;
    logic [GW-1:0]       r_hi;
    logic                r_stride2;
    logic                r_eop;
    logic                r_cfg_err;
    logic [9*DATA_W-1:0] r_win_data;

    logic [DATA_W-1:0]   r_lb0 [MAX_W];
    logic [DATA_W-1:0]   r_lb1 [MAX_W];
    logic [DATA_W-1:0]   r_win [3][3];

    logic [GW-1:0]       w_wi_cfg;
    logic [GW-1:0]       w_hi_cfg;
    logic                w_cfg_ok;
    logic                w_stride_ok;
    logic                w_border;
    logic                w_accept;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_eop_now;
    logic                w_emit;
    logic [AW-1:0]       w_lb_idx;
    logic [DATA_W-1:0]   w_pix;
    logic [DATA_W-1:0]   w_col_in [3];
    logic [DATA_W-1:0]   w_win_nxt [3][3];
    logic [9*DATA_W-1:0] w_win_flat;

    assign w_stride_ok = (i_cfg_stride == 2'd1) || (i_cfg_stride == 2'd2);

`ifdef CONV_PAD_EN
    assign w_wi_cfg = {1'b0, i_cfg_width}  + GW'(2);
    assign w_hi_cfg = {1'b0, i_cfg_height} + GW'(2);
    assign w_cfg_ok = (i_cfg_width >= CNT_W'(1)) && (i_cfg_height >= CNT_W'(1)) &&
                      (w_wi_cfg <= GW'(MAX_W)) && w_stride_ok;
    assign w_border = (r_row == '0) || (r_col == '0) || w_last_row || w_last_col;
`else
    assign w_wi_cfg = {1'b0, i_cfg_width};
    assign w_hi_cfg = {1'b0, i_cfg_height};
    assign w_cfg_ok = (i_cfg_width >= CNT_W'(3)) && (i_cfg_height >= CNT_W'(3)) &&
                      (w_wi_cfg <= GW'(MAX_W)) && w_stride_ok;
    assign w_border = 1'b0;
`endif

    assign w_last_col = (r_col == r_wi - GW'(1));
    assign w_last_row = (r_row == r_hi - GW'(1));
    assign w_eop_now  = w_last_row && w_last_col;
    assign w_accept   = (r_state == S_RUN) && (w_border || i_pix_valid);
    assign w_pix      = w_border ? '0 : i_pix_data;
    assign w_lb_idx   = r_col[AW-1:0];

    // With stride 2, (pos-2)%2==0 reduces to pos being even.
    assign w_emit = (r_row >= GW'(2)) && (r_col >= GW'(2)) &&
                    (!r_stride2 || (!r_row[0] && !r_col[0]));

    assign w_col_in[0] = r_lb1[w_lb_idx];
    assign w_col_in[1] = r_lb0[w_lb_idx];
    assign w_col_in[2] = w_pix;

    always_comb begin
        w_win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[r][0] = r_win[r][1];
            w_win_nxt[r][1] = r_win[r][2];
            w_win_nxt[r][2] = w_col_in[r];
            for (int c = 0; c < 3; c++) begin
                w_win_flat[DATA_W*(3*r+c) +: DATA_W] = w_win_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        o_pix_ready  = 1'b0;
        o_win_valid  = 1'b0;
        o_busy       = 1'b1;
        o_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start && w_cfg_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_pix_ready = !w_border;
                if (w_accept) begin
                    if (w_emit) begin
                        w_state_nxt = S_HOLD;
                    end else if (w_eop_now) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_HOLD: begin
                o_win_valid = 1'b1;
                if (i_win_ready) begin
                    w_state_nxt = r_eop ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                o_frame_done = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_wi       <= '0;
            r_hi       <= '0;
            r_stride2  <= 1'b0;
            r_eop      <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_win_data <= '0;
            r_win      <= '{default: '0};
        end else begin
            r_cfg_err <= 1'b0;
            if (r_state == S_IDLE && i_start) begin
                if (w_cfg_ok) begin
                    r_wi      <= w_wi_cfg;
                    r_hi      <= w_hi_cfg;
                    r_stride2 <= (i_cfg_stride == 2'd2);
                    r_row     <= '0;
                    r_col     <= '0;
                    r_eop     <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end
            if (w_accept) begin
                r_win <= w_win_nxt;
                if (w_emit) begin
                    r_win_data <= w_win_flat;
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + GW'(1);
                end else begin
                    r_col <= r_col + GW'(1);
                end
                if (w_eop_now) begin
                    r_eop <= 1'b1;
                end
            end
        end
    end

    // NOTE: line buffer RAM has no reset; rows are always rewritten before a window can read them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_lb_idx] <= w_col_in[1];
            r_lb0[w_lb_idx] <= w_pix;
        end
    end

    assign o_win_data = r_win_data;
    assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Scoreboard bench for conv_window_gen_3x3: a plane model queues expected windows,
// a negedge monitor pops and compares every accepted window.
module tb_conv_window_gen_3x3;

    localparam int DATA_W = 16;
    localparam int MAX_W  = 256;
    localparam int CNT_W  = 10;
    localparam int WV     = 9 * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [CNT_W-1:0]  i_cfg_width = '0;
    logic [CNT_W-1:0]  i_cfg_height = '0;
    logic [1:0]        i_cfg_stride = '0;
    logic [DATA_W-1:0] i_pix_data = '0;
    logic              i_pix_valid = 1'b0;
    logic              o_pix_ready;
    logic [WV-1:0]     o_win_data;
    logic              o_win_valid;
    logic              i_win_ready = 1'b1;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WV-1:0] exp_q [$];
    int            frame_cnt  = 0;
    int            plane_id   = 0;
    int            hold_req   = 0;
    int            hold_plane = -1;
    int            hold_left  = 0;
    logic [WV-1:0] held_data  = '0;

    conv_window_gen_3x3 #(.DATA_W(DATA_W), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_cfg_width  (i_cfg_width),
        .i_cfg_height (i_cfg_height),
        .i_cfg_stride (i_cfg_stride),
        .i_pix_data   (i_pix_data),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .o_win_data   (o_win_data),
        .o_win_valid  (o_win_valid),
        .i_win_ready  (i_win_ready),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_cfg_err    (o_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WV-1:0] obs, input logic [WV-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Pixel at internal grid position; stream values are 1..W*H in raster order.
    function automatic logic [DATA_W-1:0] grid_px(input int r, input int c, input int w,
                                                   input int h, input bit pad);
        if (pad) begin
            if (r == 0 || c == 0 || r == h + 1 || c == w + 1) return '0;
            return DATA_W'((r - 1) * w + c);
        end
        return DATA_W'(r * w + c + 1);
    endfunction

    task automatic push_expected(input int w, input int h, input int s, input bit pad);
        int wi = pad ? w + 2 : w;
        int hi = pad ? h + 2 : h;
        logic [WV-1:0] v;
        for (int r0 = 0; r0 + 2 < hi; r0 += s) begin
            for (int c0 = 0; c0 + 2 < wi; c0 += s) begin
                v = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        v[DATA_W*(3*rr+cc) +: DATA_W] = grid_px(r0 + rr, c0 + cc, w, h, pad);
                exp_q.push_back(v);
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_frame_done) frame_cnt++;
        if (o_win_valid) begin
            check("no_pix_ready_while_win", {143'd0, o_pix_ready}, '0);
            if (hold_req > 0 && hold_plane != plane_id) begin
                hold_plane = plane_id;
                hold_left  = hold_req;
                held_data  = o_win_data;
            end
            if (hold_left > 0) begin
                check("held_win_stable", o_win_data, held_data);
                i_win_ready = 1'b0;
                hold_left--;
            end else begin
                i_win_ready = 1'b1;
                if (exp_q.size() == 0) begin
                    check("spurious_window", {143'd0, o_win_valid}, '0);
                end else begin
                    check($sformatf("win_p%0d", plane_id), o_win_data, exp_q.pop_front());
                end
            end
        end else begin
            i_win_ready = 1'b1;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, {143'd0, o_pix_ready}, '0);
        check({tag, "_win_valid"}, {143'd0, o_win_valid}, '0);
        check({tag, "_win_data"}, o_win_data, '0);
        check({tag, "_busy"}, {143'd0, o_busy}, '0);
        check({tag, "_frame_done"}, {143'd0, o_frame_done}, '0);
        check({tag, "_cfg_err"}, {143'd0, o_cfg_err}, '0);
    endtask

    // Runs one plane. bubbles: random pix_valid gaps; hold: win_ready low cycles at first window;
    // abort: reset after this many accepted pixels; start_at: illegal-in-RUN start at that pixel.
    task automatic run_plane(input int w, input int h, input int s, input bit pad, input bit bubbles,
                             input int hold, input int abort, input int start_at);
        int n = w * h;
        int idx = 1;
        int guard = 0;
        int f0 = frame_cnt;
        bit acc;
        plane_id++;
        hold_req = hold;
        if (abort == 0) push_expected(w, h, s, pad);
        @(negedge clk);
        i_cfg_width  = CNT_W'(w);
        i_cfg_height = CNT_W'(h);
        i_cfg_stride = 2'(s);
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", {143'd0, o_busy}, {143'd0, 1'b1});
        while (idx <= n && guard < 4000) begin
            i_pix_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_pix_data  = DATA_W'(idx);
            if (idx == start_at) begin
                i_start      = 1'b1;
                i_cfg_width  = CNT_W'(3);
                i_cfg_stride = 2'd2;
            end
            acc = i_pix_valid && o_pix_ready;
            @(negedge clk);
            i_start      = 1'b0;
            i_cfg_width  = CNT_W'(w);
            i_cfg_stride = 2'(s);
            if (acc) idx++;
            guard++;
            if (abort > 0 && idx > abort) begin
                i_pix_valid = 1'b0;
                rst = 1'b1;
                repeat (2) @(negedge clk);
                exp_q.delete();
                check_reset_outputs("mid_reset");
                rst = 1'b0;
                return;
            end
        end
        i_pix_valid = 1'b0;
        if (guard >= 4000) check("pixel_timeout", {143'd0, 1'b1}, '0);
        guard = 0;
        while (frame_cnt == f0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check($sformatf("frame_done_count_p%0d", plane_id), WV'(frame_cnt - f0), WV'(1));
        check($sformatf("windows_left_p%0d", plane_id), WV'(exp_q.size()), '0);
        check($sformatf("busy_cleared_p%0d", plane_id), {143'd0, o_busy}, '0);
        hold_req = 0;
    endtask

    task automatic cfg_err_case(input int w, input int h, input int s);
        @(negedge clk);
        i_cfg_width  = CNT_W'(w);
        i_cfg_height = CNT_W'(h);
        i_cfg_stride = 2'(s);
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("cfg_err_pulse", {143'd0, o_cfg_err}, {143'd0, 1'b1});
        check("cfg_err_busy", {143'd0, o_busy}, '0);
        @(negedge clk);
        check("cfg_err_one_cycle", {143'd0, o_cfg_err}, '0);
        check("cfg_err_stay_idle", {143'd0, o_pix_ready}, '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_plane(4, 4, 1, 1'b0, 1'b0, 0, 0, 0);
        run_plane(5, 5, 2, 1'b0, 1'b0, 0, 0, 0);
        run_plane(5, 5, 2, 1'b0, 1'b1, 0, 0, 0);
        run_plane(6, 5, 2, 1'b0, 1'b0, 0, 0, 0);
        run_plane(3, 3, 1, 1'b0, 1'b1, 0, 0, 0);
        run_plane(4, 4, 1, 1'b0, 1'b0, 10, 0, 0);

`ifdef CONV_PAD_EN
        cfg_err_case(0, 4, 1);
`else
        cfg_err_case(2, 4, 1);
        cfg_err_case(4, 2, 1);
`endif
        cfg_err_case(4, 4, 3);
        cfg_err_case(300, 4, 1);
        run_plane(4, 4, 1, 1'b0, 1'b0, 0, 0, 5);

        run_plane(4, 4, 1, 1'b0, 1'b0, 0, 7, 0);
        run_plane(4, 4, 1, 1'b0, 1'b0, 0, 0, 0);

`ifdef CONV_PAD_EN
        run_plane(3, 3, 1, 1'b1, 1'b0, 0, 0, 0);
        run_plane(4, 3, 2, 1'b1, 1'b1, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
